// File: rtl/ahb_lite_master.sv
// AHB-Lite single-transfer master: turns one core request into one NONSEQ
// transfer and returns a registered one-cycle completion pulse.
module ahb_lite_master #(
  parameter int unsigned RESP_REG = 1
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] HADDR,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic        HWRITE,
  output logic [31:0] HWDATA,
  input  logic        HREADY,
  input  logic [31:0] HRDATA,
  input  logic        HRESP
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;

  if (RESP_REG != 1) begin : g_resp_reg_check
    $error("ahb_lite_master: only RESP_REG=1 (registered response) is supported");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADDR  = 2'd1,
    DATA  = 2'd2,
    MISAL = 2'd3
  } state_e;

  state_e          state_q;
  logic            ready_q;
  logic [1:0]      htrans_q;
  logic [DW-1:0]   haddr_q;
  logic [2:0]      hsize_q;
  logic            hwrite_q;
  logic [DW-1:0]   hwdata_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_rdata_q;
  logic            rsp_err_q;
  logic            misal_c;

  // Halfwords need bit 0 clear, words need bits 1:0 clear; size 3 is never legal.
  assign misal_c = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (|req_addr[1:0]));

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      ready_q     <= 1'b1;
      htrans_q    <= TRANS_IDLE;
      haddr_q     <= '0;
      hsize_q     <= 3'd0;
      hwrite_q    <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ready_q  <= 1'b0;
            hwdata_q <= req_wdata;
            if (misal_c) begin
              state_q <= MISAL;
            end else begin
              state_q  <= ADDR;
              htrans_q <= TRANS_NONSEQ;
              haddr_q  <= req_addr;
              hsize_q  <= {1'b0, req_size};
              hwrite_q <= req_we;
            end
          end
        end
        ADDR: begin
          if (HREADY) begin
            state_q  <= DATA;
            htrans_q <= TRANS_IDLE;
          end
        end
        DATA: begin
          // HRESP only counts on the cycle the slave finishes the data phase.
          if (HREADY) begin
            state_q     <= IDLE;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= hwrite_q ? DW'(0) : HRDATA;
            rsp_err_q   <= HRESP;
          end
        end
        MISAL: begin
          state_q     <= IDLE;
          ready_q     <= 1'b1;
          rsp_valid_q <= 1'b1;
          rsp_rdata_q <= '0;
          rsp_err_q   <= 1'b1;
        end
        default: begin
          state_q  <= IDLE;
          ready_q  <= 1'b1;
          htrans_q <= TRANS_IDLE;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign HTRANS    = htrans_q;
  assign HADDR     = haddr_q;
  assign HSIZE     = hsize_q;
  assign HWRITE    = hwrite_q;
  assign HWDATA    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
